// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with selectable next-PC source and a circular
// return-address stack that supports call/return, overflow and underflow tracking.
module pc_unit_ras #(
    parameter int                  WIDTH     = 16,
    parameter int                  INC       = 1,
    parameter int                  RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0]    RESET_VEC = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             pc_write,
    input  logic [1:0]       pc_sel,
    input  logic [WIDTH-1:0] branch,
    input  logic [WIDTH-1:0] jump,
    input  logic             call,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);

    localparam int               PTR_W = $clog2(RAS_DEPTH);
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        SEL_INC    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_RETURN = 2'b11
    } sel_e;

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;
    logic             ret_hit;
    logic             ret_miss;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;

    assign ras_empty = (count == '0);
    assign ras_full  = (count == DEPTH_C);
    assign ras_top   = ras_empty ? '0 : ras[top_ptr];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pc_inc     = pc + INC_W;
        pc_next    = pc_inc;
        ret_hit    = (sel_e'(pc_sel) == SEL_RETURN) && !ras_empty;
        ret_miss   = (sel_e'(pc_sel) == SEL_RETURN) && ras_empty;
        // A call on a successful return swaps the top entry instead of growing the stack.
        do_replace = ret_hit && call;
        do_push    = call && !ret_hit;
        do_pop     = ret_hit && !call;
        case (sel_e'(pc_sel))
            SEL_INC:    pc_next = pc_inc;
            SEL_BRANCH: pc_next = branch;
            SEL_JUMP:   pc_next = jump;
            SEL_RETURN: pc_next = ras_empty ? pc_inc : ras_top;
            default:    pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_VEC;
            top_ptr <= '0;
            count   <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
            // NOTE: the stack is a handful of flops, so clearing it on reset is cheap and keeps ras_top defined.
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else if (pc_write) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            pc <= pc_next;
            if (do_replace) begin
                ras[top_ptr] <= pc_inc;
            end
            if (do_push) begin
                ras[top_ptr + PTR_W'(1)] <= pc_inc;
                top_ptr                  <= top_ptr + PTR_W'(1);
                if (ras_full) begin
                    ras_ovf <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
            if (do_pop) begin
                top_ptr <= top_ptr - PTR_W'(1);
                count   <= count - CNT_W'(1);
            end
            if (ret_miss) begin
                ras_unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: a queue-based model is compared on every
// falling edge, with hand-computed literal checks at the interesting points.
module tb_pc_unit_ras;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             reset;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic [WIDTH-1:0] branch;
    logic [WIDTH-1:0] jump;
    logic             call;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_ovf;
    logic             ras_unf;

    pc_unit_ras #(.WIDTH(WIDTH), .INC(1), .RAS_DEPTH(DEPTH), .RESET_VEC('0)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .branch   (branch),
        .jump     (jump),
        .call     (call),
        .pc       (pc),
        .ras_top  (ras_top),
        .ras_empty(ras_empty),
        .ras_full (ras_full),
        .ras_ovf  (ras_ovf),
        .ras_unf  (ras_unf)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    // Model state: return addresses as a queue, newest at the back.
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_stack[$];
    logic             m_ovf;
    logic             m_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [WIDTH-1:0] m_top();
        return (m_stack.size() > 0) ? m_stack[$] : '0;
    endfunction

    task automatic model_reset();
        m_pc  = '0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_push(input logic [WIDTH-1:0] v);
        m_stack.push_back(v);
        if (m_stack.size() > DEPTH) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_step(input logic [1:0] sel, input logic [WIDTH-1:0] br,
                              input logic [WIDTH-1:0] jp, input logic cl);
        logic [WIDTH-1:0] inc;
        inc = m_pc + 16'd1;
        case (sel)
            2'd0: begin m_pc = inc; if (cl) model_push(inc); end
            2'd1: begin m_pc = br;  if (cl) model_push(inc); end
            2'd2: begin m_pc = jp;  if (cl) model_push(inc); end
            default: begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack[$];
                    if (cl) m_stack[m_stack.size()-1] = inc;
                    else void'(m_stack.pop_back());
                end else begin
                    m_pc  = inc;
                    m_unf = 1'b1;
                    if (cl) model_push(inc);
                end
            end
        endcase
    endtask

    // One clock edge with the given controls; pc_write drops afterwards so idle edges hold.
    task automatic cycle(input logic we, input logic [1:0] sel, input logic [WIDTH-1:0] br,
                         input logic [WIDTH-1:0] jp, input logic cl);
        @(negedge CLK);
        #1;
        pc_write = we;
        pc_sel   = sel;
        branch   = br;
        jump     = jp;
        call     = cl;
        if (we) model_step(sel, br, jp, cl);
        @(posedge CLK);
        #1;
        pc_write = 1'b0;
        call     = 1'b0;
    endtask

    task automatic reset_now();
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_pc", pc, 0);
        check("rst_empty", ras_empty, 1);
        check("rst_full", ras_full, 0);
        check("rst_top", ras_top, 0);
        check("rst_ovf", ras_ovf, 0);
        check("rst_unf", ras_unf, 0);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("cmp_pc", pc, m_pc);
            check("cmp_top", ras_top, m_top());
            check("cmp_empty", ras_empty, m_stack.size() == 0);
            check("cmp_full", ras_full, m_stack.size() == DEPTH);
            check("cmp_ovf", ras_ovf, m_ovf);
            check("cmp_unf", ras_unf, m_unf);
        end
    end

    initial begin
        reset    = 1'b1;
        pc_write = 1'b0;
        pc_sel   = 2'b00;
        branch   = '0;
        jump     = '0;
        call     = 1'b0;
        #2;
        reset_now();
        cmp_en = 1'b1;
        release_reset();

        // Hold: pc_write low while selects and call wiggle.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'(i), 16'h0015, 16'h0040, 1'b1);
        end
        check("hold_pc", pc, 16'h0000);
        check("hold_empty", ras_empty, 1);

        // Sequential, branch and jump.
        cycle(1'b1, 2'b00, 16'h0, 16'h0, 1'b0); check("inc1", pc, 16'h0001);
        cycle(1'b1, 2'b00, 16'h0, 16'h0, 1'b0); check("inc2", pc, 16'h0002);
        cycle(1'b1, 2'b00, 16'h0, 16'h0, 1'b0); check("inc3", pc, 16'h0003);
        cycle(1'b1, 2'b01, 16'h000F, 16'h0, 1'b0); check("branch", pc, 16'h000F);
        cycle(1'b1, 2'b10, 16'h0, 16'h0040, 1'b0); check("jump", pc, 16'h0040);

        // Simple call and return.
        cycle(1'b1, 2'b10, 16'h0, 16'h0100, 1'b1);
        check("call_pc", pc, 16'h0100);
        check("call_top", ras_top, 16'h0041);
        cycle(1'b1, 2'b11, 16'h0, 16'h0, 1'b0);
        check("ret_pc", pc, 16'h0041);
        check("ret_empty", ras_empty, 1);

        // Five nested calls overflow a 4-deep stack, then drain past empty.
        cycle(1'b1, 2'b10, 16'h0, 16'h0010, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 2'b10, 16'h0, 16'((i + 1) * 16), 1'b1);
        end
        check("ovf_full", ras_full, 1);
        check("ovf_flag", ras_ovf, 1);
        cycle(1'b1, 2'b11, 16'h0, 16'h0, 1'b0); check("pop1", pc, 16'h0051);
        cycle(1'b1, 2'b11, 16'h0, 16'h0, 1'b0); check("pop2", pc, 16'h0041);
        cycle(1'b1, 2'b11, 16'h0, 16'h0, 1'b0); check("pop3", pc, 16'h0031);
        cycle(1'b1, 2'b11, 16'h0, 16'h0, 1'b0); check("pop4", pc, 16'h0021);
        cycle(1'b1, 2'b11, 16'h0, 16'h0, 1'b0);
        check("unf_pc", pc, 16'h0022);
        check("unf_flag", ras_unf, 1);

        // Wrap-around and underflow from a clean state.
        @(negedge CLK);
        #1;
        reset_now();
        release_reset();
        cycle(1'b1, 2'b10, 16'h0, 16'hFFFF, 1'b0); check("at_max", pc, 16'hFFFF);
        cycle(1'b1, 2'b00, 16'h0, 16'h0, 1'b0);
        check("wrap_pc", pc, 16'h0000);
        check("wrap_ovf", ras_ovf, 0);
        check("wrap_unf", ras_unf, 0);
        cycle(1'b1, 2'b11, 16'h0, 16'h0, 1'b0);
        check("empty_ret_pc", pc, 16'h0001);
        check("empty_ret_unf", ras_unf, 1);

        // Call on a return swaps the top entry.
        cycle(1'b1, 2'b10, 16'h0, 16'h0200, 1'b1); check("swap_pre_top", ras_top, 16'h0002);
        cycle(1'b1, 2'b11, 16'h0, 16'h0, 1'b1);
        check("swap_pc", pc, 16'h0002);
        check("swap_top", ras_top, 16'h0201);
        check("swap_empty", ras_empty, 0);

        // Second entry, then reset asserted between edges.
        cycle(1'b1, 2'b01, 16'h0300, 16'h0, 1'b1);
        check("pre_rst_top", ras_top, 16'h0003);
        @(negedge CLK);
        #2;
        reset_now();
        release_reset();
        cycle(1'b1, 2'b00, 16'h0, 16'h0, 1'b0); check("post_rst_pc", pc, 16'h0001);

        @(negedge CLK);
        #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
